// File: rtl/child_inst_rr_scheduler.sv
// -----------------------------------------------------------------------------
// child_inst_rr_scheduler
//
// Round-robin scheduler that shares one resource slot between the child
// instances of a generated root module. One child is granted at a time. The
// grant is held until that child pulses done. A one-cycle gap follows, and
// then the scheduler arbitrates again.
//
// The search for the next winner starts at the child after the last
// winner. After reset, child 0 has first priority.
//
// Optional feature (compile-time macro):
//   ARB_TIMEOUT_EN - adds a grant watchdog. A grant that has been held for
//                    TIMEOUT_CYCLES busy cycles without a done is revoked.
//                    The revoke pulses timeout_o for one cycle. Without
//                    the macro, timeout_o is tied to 0 and a grant may be
//                    held indefinitely.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset (release is expected to
//                     be synchronised to clk by the root's reset logic)
//   req_i        in   [N_CHILD]  per-child request, level
//   done_i       in   [N_CHILD]  per-child completion pulse
//   gnt_o        out  [N_CHILD]  one-hot grant, registered
//   gnt_id_o     out  [ID_W]     index of the granted child; holds when idle
//   busy_o       out  a grant is active
//   grant_cnt_o  out  [CNT_W]    total grants issued, wrapping
//   timeout_o    out  one-cycle pulse on watchdog revoke
// -----------------------------------------------------------------------------
module child_inst_rr_scheduler #(
   parameter int N_CHILD        = 5,
   parameter int ID_W           = $clog2(N_CHILD),
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_CHILD-1:0] req_i,
   input  logic [N_CHILD-1:0] done_i,
   output logic [N_CHILD-1:0] gnt_o,
   output logic [ID_W-1:0]    gnt_id_o,
   output logic               busy_o,
   output logic [CNT_W-1:0]   grant_cnt_o,
   output logic               timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [N_CHILD-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [ID_W-1:0]    winner_s;
   logic               win_vld_s;
   logic               done_s;
   logic               tmo_hit_s;
   logic               release_s;

   // Reject illegal configurations at elaboration time.
   if (N_CHILD < 2 || N_CHILD > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("child_inst_rr_scheduler: N_CHILD must be 2..16 and TIMEOUT_CYCLES >= 1");
   end

   // Circular priority search, starting at the child after the last winner.
   always_comb begin
      int          idx_v;
      logic [ID_W-1:0] idx_id_v;
      win_vld_s = 1'b0;
      winner_s  = '0;
      idx_v     = 0;
      idx_id_v  = '0;
      for (int i = 1; i <= N_CHILD; i++) begin
         idx_v = int'(last_q) + i;
         if (idx_v >= N_CHILD) begin
            idx_v = idx_v - N_CHILD;
         end else begin
            idx_v = idx_v;
         end
         idx_id_v = ID_W'(idx_v);
         if (!win_vld_s && req_i[idx_id_v]) begin
            win_vld_s = 1'b1;
            winner_s  = idx_id_v;
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   // Only the granted child's done bit matters. Bits from other children are ignored.
   assign done_s    = done_i[gnt_id_q];
   assign release_s = (state_q == ST_BUSY) && (done_s || tmo_hit_s);

`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_q, tmo_d;

   // The counter holds the number of busy cycles already completed. Revoke
   // at the last allowed cycle unless done arrives in that same cycle,
   // because done takes precedence.
   assign tmo_hit_s = (state_q == ST_BUSY) && !done_s &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Watchdog next-state: clear while idle, count busy cycles, flag revoke.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      tmo_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = '0;
         end
         ST_BUSY: begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            tmo_d     = tmo_hit_s;
         end
         default: begin
            tmo_cnt_d = tmo_cnt_q;
         end
      endcase
   end

   // Watchdog registers. The pulse lands on the GAP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_q     <= tmo_d;
      end
   end

   assign timeout_o = tmo_q;
`else
   assign tmo_hit_s = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld_s) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (release_s) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM output logic: next values of the registered grant outputs.
   always_comb begin
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld_s) begin
               gnt_d    = {{(N_CHILD-1){1'b0}}, 1'b1} << winner_s;
               gnt_id_d = winner_s;
               busy_d   = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
            end else begin
               gnt_d  = '0;
               busy_d = 1'b0;
            end
         end
         ST_BUSY: begin
            if (release_s) begin
               gnt_d  = '0;
               busy_d = 1'b0;
               last_d = gnt_id_q;
            end else begin
               gnt_d  = gnt_q;
               busy_d = 1'b1;
            end
         end
         ST_GAP: begin
            gnt_d  = '0;
            busy_d = 1'b0;
         end
         default: begin
            gnt_d  = '0;
            busy_d = 1'b0;
         end
      endcase
   end

   // Output and priority-pointer registers. last_q starts at the top index,
   // so child 0 is searched first after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         last_q   <= ID_W'(N_CHILD - 1);
      end else begin
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = gnt_id_q;
   assign busy_o      = busy_q;
   assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_child_inst_rr_scheduler.sv
module tb_child_inst_rr_scheduler;

   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] done;

   logic [N-1:0] gnt;
   logic [2:0]   gnt_id;
   logic         busy;
   logic [15:0]  cnt;
   logic         tmo;

   logic [N-1:0] w_gnt;
   logic [2:0]   w_gnt_id;
   logic         w_busy;
   logic [3:0]   w_cnt;
   logic         w_tmo;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   child_inst_rr_scheduler #(.N_CHILD(N), .CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
      .gnt_o(gnt), .gnt_id_o(gnt_id), .busy_o(busy),
      .grant_cnt_o(cnt), .timeout_o(tmo)
   );

   // narrow-counter copy makes the counter wrap reachable in a short run
   child_inst_rr_scheduler #(.N_CHILD(N), .CNT_W(4), .TIMEOUT_CYCLES(8)) dut_w (
      .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
      .gnt_o(w_gnt), .gnt_id_o(w_gnt_id), .busy_o(w_busy),
      .grant_cnt_o(w_cnt), .timeout_o(w_tmo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req   = '0;
      done  = '0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req   = '0;
      done  = '0;
      rst_n = 1'b0;
      tick();
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL reset_gnt: got %b want %b", gnt, 5'b00000); end
      n_vec++; if (gnt_id !== 3'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL reset_tmo: got %b want 0", tmo); end
      rst_n = 1'b1;
      tick();
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL idle_gnt: got %b want %b", gnt, 5'b00000); end
   endtask

   task automatic test_single();
      req = 5'b00100;
      tick();
      n_vec++; if (gnt !== 5'b00100) begin n_err++; $display("FAIL single_gnt: got %b want %b", gnt, 5'b00100); end
      n_vec++; if (gnt_id !== 3'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", gnt_id); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
      n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", cnt); end
      done = 5'b00100;
      req  = 5'b00000;
      tick();
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL single_rel_gnt: got %b want %b", gnt, 5'b00000); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_rel_busy: got %b want 0", busy); end
      n_vec++; if (gnt_id !== 3'd2) begin n_err++; $display("FAIL single_id_hold: got %0d want 2", gnt_id); end
      done = 5'b00000;
      tick();
      tick();
   endtask

   task automatic test_rotation();
      int           exp_id;
      int           n;
      logic [N-1:0] oh;
      apply_reset();
      req    = 5'b11111;
      exp_id = 0;
      for (int g = 0; g < 6; g++) begin
         n = 0;
         while (gnt === 5'b00000 && n < 12) begin
            tick();
            n++;
         end
         oh = 5'b00001 << exp_id;
         n_vec++; if (gnt !== oh) begin n_err++; $display("FAIL rot_gnt[%0d]: got %b want %b", g, gnt, oh); end
         n_vec++; if (gnt_id !== 3'(exp_id)) begin n_err++; $display("FAIL rot_id[%0d]: got %0d want %0d", g, gnt_id, exp_id); end
         n_vec++; if (n != ((g == 0) ? 1 : 2)) begin n_err++; $display("FAIL rot_spacing[%0d]: got %0d edges want %0d", g, n, (g == 0) ? 1 : 2); end
         tick();
         tick();
         done = oh;
         tick();
         n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL rot_release[%0d]: got %b want %b", g, gnt, 5'b00000); end
         done   = 5'b00000;
         exp_id = (exp_id + 1) % N;
      end
      n_vec++; if (cnt !== 16'd6) begin n_err++; $display("FAIL rot_cnt: got %0d want 6", cnt); end
      req = 5'b00000;
      tick();
      tick();
   endtask

   task automatic test_lock();
      apply_reset();
      req = 5'b00010;
      tick();
      n_vec++; if (gnt !== 5'b00010) begin n_err++; $display("FAIL lock_gnt: got %b want %b", gnt, 5'b00010); end
      req  = 5'b00000;
      done = 5'b01000;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++; if (gnt !== 5'b00010) begin n_err++; $display("FAIL lock_hold[%0d]: got %b want %b", k, gnt, 5'b00010); end
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL lock_busy[%0d]: got %b want 1", k, busy); end
      end
      done = 5'b00010;
      tick();
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL lock_release: got %b want %b", gnt, 5'b00000); end
      n_vec++; if (gnt_id !== 3'd1) begin n_err++; $display("FAIL lock_id_hold: got %0d want 1", gnt_id); end
      done = 5'b00000;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req = 5'b01000;
      tick();
      n_vec++; if (gnt !== 5'b01000) begin n_err++; $display("FAIL rstmid_pre: got %b want %b", gnt, 5'b01000); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL rstmid_gnt: got %b want %b", gnt, 5'b00000); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_vec++; if (gnt_id !== 3'd0) begin n_err++; $display("FAIL rstmid_id: got %0d want 0", gnt_id); end
      n_vec++; if (cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 0", cnt); end
      req = 5'b11000;
      #1;
      rst_n = 1'b1;
      tick();
      n_vec++; if (gnt !== 5'b01000) begin n_err++; $display("FAIL rstmid_regrant: got %b want %b", gnt, 5'b01000); end
      n_vec++; if (gnt_id !== 3'd3) begin n_err++; $display("FAIL rstmid_regrant_id: got %0d want 3", gnt_id); end
      n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL rstmid_regrant_cnt: got %0d want 1", cnt); end
      done = 5'b01000;
      req  = 5'b00000;
      tick();
      done = 5'b00000;
      tick();
      tick();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      apply_reset();
      req = 5'b10000;
      tick();
      n_vec++; if (gnt !== 5'b10000) begin n_err++; $display("FAIL tmo_gnt: got %b want %b", gnt, 5'b10000); end
      n_vec++; if (gnt_id !== 3'd4) begin n_err++; $display("FAIL tmo_id: got %0d want 4", gnt_id); end
      req = 5'b10001;
      for (int k = 2; k <= 8; k++) begin
         tick();
         n_vec++; if (gnt !== 5'b10000) begin n_err++; $display("FAIL tmo_hold[%0d]: got %b want %b", k, gnt, 5'b10000); end
         n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL tmo_early[%0d]: got %b want 0", k, tmo); end
      end
      tick();
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL tmo_revoke: got %b want %b", gnt, 5'b00000); end
      n_vec++; if (tmo !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: got %b want 1", tmo); end
      tick();
      n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL tmo_pulse_end: got %b want 0", tmo); end
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL tmo_idle: got %b want %b", gnt, 5'b00000); end
      tick();
      n_vec++; if (gnt !== 5'b00001) begin n_err++; $display("FAIL tmo_next: got %b want %b", gnt, 5'b00001); end
      done = 5'b00001;
      req  = 5'b00000;
      tick();
      done = 5'b00000;
      tick();
      tick();
   endtask
`else
   task automatic test_timeout();
      apply_reset();
      req = 5'b10000;
      tick();
      n_vec++; if (gnt !== 5'b10000) begin n_err++; $display("FAIL hold_gnt: got %b want %b", gnt, 5'b10000); end
      req = 5'b00000;
      for (int k = 0; k < 20; k++) begin
         tick();
         n_vec++; if (gnt !== 5'b10000) begin n_err++; $display("FAIL hold_long[%0d]: got %b want %b", k, gnt, 5'b10000); end
         n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL hold_tmo[%0d]: got %b want 0", k, tmo); end
      end
      done = 5'b10000;
      tick();
      n_vec++; if (gnt !== 5'b00000) begin n_err++; $display("FAIL hold_release: got %b want %b", gnt, 5'b00000); end
      done = 5'b00000;
      tick();
      tick();
   endtask
`endif

   task automatic test_back_to_back_wrap();
      int grants;
      int cyc;
      int last_cyc;
      apply_reset();
      req      = 5'b00001;
      done     = 5'b00001;
      grants   = 0;
      cyc      = 0;
      last_cyc = 0;
      while (grants < 16 && cyc < 100) begin
         tick();
         cyc++;
         if (gnt !== 5'b00000) begin
            grants++;
            n_vec++; if (gnt !== 5'b00001) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want %b", grants, gnt, 5'b00001); end
            if (grants > 1) begin
               n_vec++; if (cyc - last_cyc != 3) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", grants, cyc - last_cyc); end
            end
            last_cyc = cyc;
            if (grants == 15) begin
               n_vec++; if (cnt !== 16'd15) begin n_err++; $display("FAIL wrap_cnt15: got %0d want 15", cnt); end
               n_vec++; if (w_cnt !== 4'hF) begin n_err++; $display("FAIL wrap_narrow_max: got %0d want 15", w_cnt); end
            end
            if (grants == 16) begin
               n_vec++; if (cnt !== 16'd16) begin n_err++; $display("FAIL wrap_cnt16: got %0d want 16", cnt); end
               n_vec++; if (w_cnt !== 4'h0) begin n_err++; $display("FAIL wrap_narrow_zero: got %0d want 0", w_cnt); end
            end
         end
      end
      n_vec++; if (grants != 16) begin n_err++; $display("FAIL b2b_grants: got %0d want 16", grants); end
      req  = 5'b00000;
      done = 5'b00000;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_lock();
      test_reset_mid();
      test_timeout();
      test_back_to_back_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

endmodule
